// File: rtl/uart_baud_sched_if.sv
// rtl/uart_baud_sched_if.sv - mode/TC/start inputs and enable/tick/end outputs of the UART baud scheduler
interface uart_baud_sched_if;
    logic [1:0] SM;
    logic       SMOD;
    logic       TC;
    logic       tx_start;
    logic       rx_start;
    logic       rxd;
    logic       TEN;
    logic       REN;
    logic       tx_tick;
    logic       rx_sample;
    logic       tx_end;
    logic       rx_end;
    logic       rx_abort;

    modport master (
        output SM, SMOD, TC, tx_start, rx_start, rxd,
        input  TEN, REN, tx_tick, rx_sample, tx_end, rx_end, rx_abort
    );

    modport slave (
        input  SM, SMOD, TC, tx_start, rx_start, rxd,
        output TEN, REN, tx_tick, rx_sample, tx_end, rx_end, rx_abort
    );
endinterface

// File: rtl/uart_baud_sched.sv
// rtl/uart_baud_sched.sv - TX/RX bit scheduler driven by a shared baud overflow pulse
// Optional macro UART_RX_FALSE_START_EN enables RX false-start abort on the first sample.
module uart_baud_sched (
    input  logic              clk,
    input  logic              rst_n,
    uart_baud_sched_if.slave  bus
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t     tx_state, rx_state;
    logic [1:0] tx_sm, rx_sm;
    logic       tx_smod, rx_smod;
    logic [4:0] txpre, rxpre;
    logic [3:0] txbit, rxbit;
    logic       ten_q, ren_q, tx_tick_q, rx_sample_q, tx_end_q, rx_end_q;

    function automatic logic [4:0] div_last(input logic [1:0] sm, input logic smod);
        if (sm == 2'd0) return 5'd0;
        return smod ? 5'd15 : 5'd31;
    endfunction

    // Mid-bit point is div/2-1; shift mode samples on every TC.
    function automatic logic [4:0] mid_pt(input logic [1:0] sm, input logic smod);
        if (sm == 2'd0) return 5'd0;
        return smod ? 5'd7 : 5'd15;
    endfunction

    function automatic logic [3:0] bit_last(input logic [1:0] sm);
        case (sm)
            2'd0:    return 4'd7;
            2'd1:    return 4'd9;
            default: return 4'd10;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state  <= IDLE;
            tx_sm     <= 2'd0;
            tx_smod   <= 1'b0;
            txpre     <= 5'd0;
            txbit     <= 4'd0;
            ten_q     <= 1'b0;
            tx_tick_q <= 1'b0;
            tx_end_q  <= 1'b0;
        end else begin
            tx_tick_q <= 1'b0;
            tx_end_q  <= 1'b0;
            case (tx_state)
                IDLE: if (bus.tx_start) begin
                    tx_state <= RUN;
                    ten_q    <= 1'b1;
                    tx_sm    <= bus.SM;
                    tx_smod  <= bus.SMOD;
                    txpre    <= 5'd0;
                    txbit    <= 4'd0;
                end
                RUN: if (bus.TC) begin
                    if (txpre == div_last(tx_sm, tx_smod)) begin
                        txpre     <= 5'd0;
                        tx_tick_q <= 1'b1;
                        txbit     <= txbit + 4'd1;
                        if (txbit == bit_last(tx_sm)) begin
                            tx_end_q <= 1'b1;
                            tx_state <= IDLE;
                            ten_q    <= 1'b0;
                        end
                    end else begin
                        txpre <= txpre + 5'd1;
                    end
                end
                default: tx_state <= IDLE;
            endcase
        end
    end

`ifdef UART_RX_FALSE_START_EN
    logic rx_abort_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state    <= IDLE;
            rx_sm       <= 2'd0;
            rx_smod     <= 1'b0;
            rxpre       <= 5'd0;
            rxbit       <= 4'd0;
            ren_q       <= 1'b0;
            rx_sample_q <= 1'b0;
            rx_end_q    <= 1'b0;
`ifdef UART_RX_FALSE_START_EN
            rx_abort_q  <= 1'b0;
`endif
        end else begin
            rx_sample_q <= 1'b0;
            rx_end_q    <= 1'b0;
`ifdef UART_RX_FALSE_START_EN
            rx_abort_q  <= 1'b0;
`endif
            case (rx_state)
                IDLE: if (bus.rx_start) begin
                    rx_state <= RUN;
                    ren_q    <= 1'b1;
                    rx_sm    <= bus.SM;
                    rx_smod  <= bus.SMOD;
                    rxpre    <= 5'd0;
                    rxbit    <= 4'd0;
                end
                RUN: if (bus.TC) begin
                    rxpre <= (rxpre == div_last(rx_sm, rx_smod)) ? 5'd0 : rxpre + 5'd1;
                    if (rxpre == mid_pt(rx_sm, rx_smod)) begin
                        rx_sample_q <= 1'b1;
                        rxbit       <= rxbit + 4'd1;
`ifdef UART_RX_FALSE_START_EN
                        // A high line at the start-bit centre means the start edge was noise.
                        if (rxbit == 4'd0 && bus.rxd) begin
                            rx_abort_q <= 1'b1;
                            rx_state   <= IDLE;
                            ren_q      <= 1'b0;
                        end else
`endif
                        if (rxbit == bit_last(rx_sm)) begin
                            rx_end_q <= 1'b1;
                            rx_state <= IDLE;
                            ren_q    <= 1'b0;
                        end
                    end
                end
                default: rx_state <= IDLE;
            endcase
        end
    end

    assign bus.TEN       = ten_q;
    assign bus.REN       = ren_q;
    assign bus.tx_tick   = tx_tick_q;
    assign bus.rx_sample = rx_sample_q;
    assign bus.tx_end    = tx_end_q;
    assign bus.rx_end    = rx_end_q;
`ifdef UART_RX_FALSE_START_EN
    assign bus.rx_abort  = rx_abort_q;
`else
    logic unused_rxd;
    assign unused_rxd    = bus.rxd;
    assign bus.rx_abort  = 1'b0;
`endif
endmodule

// File: tb/tb_uart_baud_sched.sv
// tb/tb_uart_baud_sched.sv - directed self-checking bench for uart_baud_sched
module tb_uart_baud_sched;
    logic clk = 1'b0;
    logic rst_n;
    uart_baud_sched_if bus ();

    uart_baud_sched dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    int tc_per, tc_cnt, step;
    int n_tick, first_tick, last_tick, gmin_t, gmax_t, n_tend, tend_at, ten_cyc;
    int n_samp, first_samp, last_samp, gmin_r, gmax_r, n_rend, rend_at, ren_cyc, n_abort;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int outs();
        return int'({bus.TEN, bus.REN, bus.tx_tick, bus.rx_sample,
                     bus.tx_end, bus.rx_end, bus.rx_abort});
    endfunction

    task automatic clr(input int per);
        tc_per = per; tc_cnt = 0; step = 0;
        n_tick = 0; first_tick = -1; last_tick = -1; gmin_t = 1000000; gmax_t = 0;
        n_tend = 0; tend_at = -1; ten_cyc = 0;
        n_samp = 0; first_samp = -1; last_samp = -1; gmin_r = 1000000; gmax_r = 0;
        n_rend = 0; rend_at = -1; ren_cyc = 0; n_abort = 0;
    endtask

    // One clock per iteration: TC driven before the edge, outputs observed 1ns after it.
    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            bus.TC = (tc_per != 0) && (tc_cnt == tc_per - 1);
            @(posedge clk);
            #1;
            tc_cnt = (tc_cnt == tc_per - 1) ? 0 : tc_cnt + 1;
            if (bus.tx_tick) begin
                n_tick++;
                if (n_tick == 1) first_tick = step;
                else begin
                    if (step - last_tick < gmin_t) gmin_t = step - last_tick;
                    if (step - last_tick > gmax_t) gmax_t = step - last_tick;
                end
                last_tick = step;
            end
            if (bus.tx_end) begin n_tend++; tend_at = step; end
            if (bus.TEN) ten_cyc++;
            if (bus.rx_sample) begin
                n_samp++;
                if (n_samp == 1) first_samp = step;
                else begin
                    if (step - last_samp < gmin_r) gmin_r = step - last_samp;
                    if (step - last_samp > gmax_r) gmax_r = step - last_samp;
                end
                last_samp = step;
            end
            if (bus.rx_end) begin n_rend++; rend_at = step; end
            if (bus.REN) ren_cyc++;
            if (bus.rx_abort) n_abort++;
            step++;
        end
        bus.TC = 1'b0;
    endtask

    task automatic chk_tx10(input string tag);
        chk({tag, "_ticks"}, n_tick, 10);
        chk({tag, "_first"}, first_tick, 63);
        chk({tag, "_gapmin"}, gmin_t, 64);
        chk({tag, "_gapmax"}, gmax_t, 64);
        chk({tag, "_nend"}, n_tend, 1);
        chk({tag, "_end_at"}, tend_at, 639);
        chk({tag, "_ten_cyc"}, ten_cyc, 639);
        chk({tag, "_ten_after"}, int'(bus.TEN), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.SM = 2'd0; bus.SMOD = 1'b0; bus.TC = 1'b0;
        bus.tx_start = 1'b0; bus.rx_start = 1'b0; bus.rxd = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", outs(), 0);
        rst_n = 1'b1;

        // Mode 1, doubler on, TC every 4 cycles: 64-cycle bit time.
        clr(4);
        bus.SM = 2'd1; bus.SMOD = 1'b1; bus.tx_start = 1'b1;
        run(1);
        bus.tx_start = 1'b0;
        chk("t1_ten_next", int'(bus.TEN), 1);
        run(700);
        chk_tx10("t1");
        chk("t1_rx_idle", ren_cyc, 0);

        // Shift mode RX: sample one cycle after every TC.
        clr(6);
        bus.SM = 2'd0; bus.rx_start = 1'b1;
        run(1);
        bus.rx_start = 1'b0;
        run(60);
        chk("t2_samples", n_samp, 8);
        chk("t2_first", first_samp, 5);
        chk("t2_gap", gmax_r, 6);
        chk("t2_end_at", rend_at, 47);
        chk("t2_ren_cyc", ren_cyc, 47);

        // Mode 3, no doubler, TC every 2 cycles.
        clr(2);
        bus.SM = 2'd3; bus.SMOD = 1'b0; bus.rxd = 1'b0; bus.rx_start = 1'b1;
        run(1);
        bus.rx_start = 1'b0;
        run(720);
        chk("t3_samples", n_samp, 11);
        chk("t3_first", first_samp, 31);
        chk("t3_gapmin", gmin_r, 64);
        chk("t3_gapmax", gmax_r, 64);
        chk("t3_nend", n_rend, 1);
        chk("t3_end_at", rend_at, 671);
        chk("t3_abort", n_abort, 0);

        // Line still high at the start-bit centre.
        clr(2);
        bus.SM = 2'd2; bus.SMOD = 1'b1; bus.rxd = 1'b1; bus.rx_start = 1'b1;
        run(1);
        bus.rx_start = 1'b0;
        run(400);
        chk("t4_first", first_samp, 15);
`ifdef UART_RX_FALSE_START_EN
        chk("t4_samples", n_samp, 1);
        chk("t4_abort", n_abort, 1);
        chk("t4_nend", n_rend, 0);
        chk("t4_ren_cyc", ren_cyc, 15);
`else
        chk("t4_samples", n_samp, 11);
        chk("t4_abort", n_abort, 0);
        chk("t4_end_at", rend_at, 335);
        chk("t4_ren_cyc", ren_cyc, 335);
`endif
        bus.rxd = 1'b0;

        // Restart request and mode change mid-frame are ignored.
        clr(4);
        bus.SM = 2'd1; bus.SMOD = 1'b1; bus.tx_start = 1'b1;
        run(1);
        bus.tx_start = 1'b0;
        run(99);
        bus.SM = 2'd2; bus.tx_start = 1'b1;
        run(1);
        bus.tx_start = 1'b0;
        run(600);
        chk_tx10("t5");

        // Both FSMs on one TC stream, then asynchronous reset mid-frame.
        clr(4);
        bus.SM = 2'd1; bus.SMOD = 1'b1; bus.tx_start = 1'b1; bus.rx_start = 1'b1;
        run(1);
        bus.tx_start = 1'b0; bus.rx_start = 1'b0;
        run(199);
        chk("t6_ticks", n_tick, 3);
        chk("t6_samples", n_samp, 3);
        chk("t6_running", outs() & 7'h60, 7'h60);
        rst_n = 1'b0;
        #2;
        chk("t6_async_rst", outs(), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("t6_rst_hold", outs(), 0);
        rst_n = 1'b1;
        clr(4);
        bus.tx_start = 1'b1;
        run(1);
        bus.tx_start = 1'b0;
        run(700);
        chk_tx10("t6");
        chk("t6_rx_stays_idle", ren_cyc, 0);

        // TC while idle is ignored; a start in the tx_end cycle is accepted.
        clr(2);
        bus.SM = 2'd0;
        run(6);
        chk("t7_idle_ticks", n_tick, 0);
        clr(2);
        bus.tx_start = 1'b1;
        run(1);
        bus.tx_start = 1'b0;
        run(15);
        chk("t7_end_now", int'(bus.tx_end), 1);
        bus.tx_start = 1'b1;
        clr(2);
        run(1);
        bus.tx_start = 1'b0;
        chk("t7_restart_ten", int'(bus.TEN), 1);
        run(20);
        chk("t7_ticks", n_tick, 8);
        chk("t7_first", first_tick, 1);
        chk("t7_gap", gmax_t, 2);
        chk("t7_end_at", tend_at, 15);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
